pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/sat_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
// Control vectors bundle the four register enables and two bubble-insert flushes.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  // Field values a flushed pipeline register loads in place of its d input.
  localparam logic BUBBLE_REG_WR = 1'b0;
  localparam logic BUBBLE_JALR   = 1'b0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN      = ctrl_t'(6'b111100);
  localparam ctrl_t CTRL_FREEZE   = ctrl_t'(6'b000000);
  localparam ctrl_t CTRL_REDIRECT = ctrl_t'(6'b111111);
  localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(6'b001101);
  localparam ctrl_t CTRL_RESET    = ctrl_t'(6'b011111);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, EX redirect flush and memory freeze,
// with saturating stall/flush counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events,
  output logic              mem_err
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;
  ctrl_t            ctrl;
  logic             freeze;
  logic             load_use;
  logic             redirect_evt;

  assign load_use = ex_is_load &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl         = CTRL_RUN;
    state_d      = RUN;
    tmo_d        = '0;
    mem_err_d    = mem_err_q;
    redirect_evt = 1'b0;
    // Once frozen, EX is held, so only mem_ready can release the pipeline.
    freeze       = (state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (freeze) begin
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
      // Every frozen cycle, including the one that enters MEM_WAIT, counts as a wait cycle.
      tmo_d   = (tmo_q == TMO_W'(MEM_TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
      if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) mem_err_d = 1'b1;
    end else if (ex_redirect) begin
      ctrl         = CTRL_REDIRECT;
      redirect_evt = 1'b1;
    end else if (load_use && (state_q != LOAD_STALL)) begin
      ctrl    = CTRL_LOAD_USE;
      state_d = LOAD_STALL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (rst_n && !ctrl.pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (redirect_evt),
    .count (flush_events)
  );

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW   = 3;
  localparam int CNT_W    = 4;
  localparam int TMO      = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic              id_uses_rs, id_uses_rt, ex_is_load, ex_redirect, mem_req, mem_ready;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
  logic [CNT_W-1:0]  stall_cycles, flush_events;
  logic              mem_err;
  logic [5:0]        ctrl_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the pipeline did last cycle, plus counters as plain integers.
  bit m_frozen, m_after_stall, m_err;
  int m_wait, m_stall, m_flush;

  typedef struct packed {
    logic [5:0] ctrl;
    logic       freeze;
    logic       redir;
    logic       lu;
  } pred_t;

  typedef struct {
    string      name;
    logic       ld;
    logic [2:0] rd, rs, rt;
    logic       urs, urt, redir, req, rdy;
    logic [5:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush};

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .mem_err      (mem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pred_t predict();
    pred_t p;
    bit    hazard;
    p = '0;
    if (!rst_n) begin
      p.ctrl = 6'b011111;
      return p;
    end
    hazard = ex_is_load && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    p.freeze = m_frozen ? !mem_ready : (mem_req && !mem_ready);
    if (p.freeze)                         p.ctrl = 6'b000000;
    else if (ex_redirect)                 begin p.ctrl = 6'b111111; p.redir = 1'b1; end
    else if (hazard && !m_after_stall)    begin p.ctrl = 6'b001101; p.lu = 1'b1; end
    else                                  p.ctrl = 6'b111100;
    return p;
  endfunction

  task automatic advance(input pred_t p);
    if (!rst_n) begin
      m_frozen = 0; m_after_stall = 0; m_err = 0;
      m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!p.ctrl[5] && m_stall < CNT_MAX) m_stall++;
      if (p.redir && m_flush < CNT_MAX)    m_flush++;
      if (p.freeze) begin
        if (m_wait < TMO) m_wait++;
        if (m_wait >= TMO) m_err = 1;
      end else begin
        m_wait = 0;
      end
      m_frozen      = p.freeze;
      m_after_stall = p.lu;
    end
  endtask

  // One clock cycle with the inputs currently applied.
  task automatic tick(input string name, input bit use_exp, input logic [5:0] exp_ctrl);
    pred_t p;
    #1;
    p = predict();
    check({name, " ctrl/model"}, ctrl_vec, p.ctrl);
    if (use_exp) check({name, " ctrl/table"}, ctrl_vec, exp_ctrl);
    @(posedge clk);
    advance(p);
    #1;
    check({name, " stall_cycles"}, stall_cycles, m_stall);
    check({name, " flush_events"}, flush_events, m_flush);
    check({name, " mem_err"}, mem_err, m_err);
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_is_load = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick("reset", 1, 6'b011111);
    rst_n = 1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"idle",            0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100};
    vecs[1] = '{"lu_rs",           1, 3, 3, 1, 1, 0, 0, 0, 0, 6'b001101};
    vecs[2] = '{"lu_rt",           1, 5, 2, 5, 0, 1, 0, 0, 0, 6'b001101};
    vecs[3] = '{"rs_unused",       1, 3, 3, 1, 0, 0, 0, 0, 0, 6'b111100};
    vecs[4] = '{"not_load",        0, 4, 4, 4, 1, 1, 0, 0, 0, 6'b111100};
    vecs[5] = '{"lu_r0",           1, 0, 0, 7, 1, 0, 0, 0, 0, 6'b001101};
    vecs[6] = '{"redir_over_lu",   1, 3, 3, 0, 1, 0, 1, 0, 0, 6'b111111};
    vecs[7] = '{"freeze_over_all", 1, 3, 3, 0, 1, 0, 1, 1, 0, 6'b000000};
    vecs[8] = '{"mem_hit",         0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b111100};
    vecs[9] = '{"rdy_no_req",      0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b111111};

    idle_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      do_reset();
      ex_is_load = vecs[i].ld;   ex_rd = vecs[i].rd;
      id_rs = vecs[i].rs;        id_rt = vecs[i].rt;
      id_uses_rs = vecs[i].urs;  id_uses_rt = vecs[i].urt;
      ex_redirect = vecs[i].redir;
      mem_req = vecs[i].req;     mem_ready = vecs[i].rdy;
      tick(vecs[i].name, 1, vecs[i].exp);
    end

    // Load-use: one bubble, then the stall state masks the still-present hazard.
    do_reset();
    ex_is_load = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
    tick("lu_seq stall", 1, 6'b001101);
    check("lu_seq stall_cycles", stall_cycles, 1);
    tick("lu_seq resume", 1, 6'b111100);
    check("lu_seq stall_hold", stall_cycles, 1);

    // Redirect beats a same-cycle load-use and costs no stall.
    do_reset();
    ex_is_load = 1; ex_rd = 2; id_rt = 2; id_uses_rt = 1; ex_redirect = 1;
    tick("redir_seq", 1, 6'b111111);
    check("redir_seq flush_events", flush_events, 1);
    check("redir_seq stall_cycles", stall_cycles, 0);

    // Memory freeze for three cycles, advance on the ready cycle.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 3; c++) tick("freeze_seq wait", 1, 6'b000000);
    mem_ready = 1;
    tick("freeze_seq ready", 1, 6'b111100);
    check("freeze_seq stall_cycles", stall_cycles, 3);
    check("freeze_seq no_err", mem_err, 0);

    // Timeout after four wait cycles; sticky until reset, reset abandons a wait.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 3; c++) tick("tmo_seq wait", 1, 6'b000000);
    check("tmo_seq before", mem_err, 0);
    tick("tmo_seq wait4", 1, 6'b000000);
    check("tmo_seq set", mem_err, 1);
    mem_ready = 1;
    tick("tmo_seq ready", 1, 6'b111100);
    mem_req = 0; mem_ready = 0;
    tick("tmo_seq after", 1, 6'b111100);
    check("tmo_seq sticky", mem_err, 1);
    mem_req = 1;
    tick("tmo_seq rewait", 1, 6'b000000);
    tick("tmo_seq rewait2", 1, 6'b000000);
    rst_n = 0;
    tick("tmo_seq reset", 1, 6'b011111);
    check("tmo_seq rst stall", stall_cycles, 0);
    check("tmo_seq rst flush", flush_events, 0);
    check("tmo_seq rst err", mem_err, 0);
    rst_n = 1; mem_req = 0; mem_ready = 0;
    tick("tmo_seq run_after_rst", 1, 6'b111100);

    // Saturation: 20 frozen cycles on a 4-bit counter.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 20; c++) tick("sat_seq", 1, 6'b000000);
    check("sat_seq stall_cycles", stall_cycles, CNT_MAX);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_n       = ($urandom_range(39, 0) != 0);
      ex_is_load  = $urandom_range(1, 0);
      ex_rd       = REG_AW'($urandom_range(3, 0));
      id_rs       = REG_AW'($urandom_range(3, 0));
      id_rt       = REG_AW'($urandom_range(3, 0));
      id_uses_rs  = $urandom_range(1, 0);
      id_uses_rt  = $urandom_range(1, 0);
      ex_redirect = ($urandom_range(4, 0) == 0);
      mem_req     = $urandom_range(1, 0);
      mem_ready   = ($urandom_range(2, 0) != 0);
      tick("random", 0, 6'b000000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
